// File: rtl/mem_wb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and default widths for the MEM/WB pipeline register.
//   PIPE_DATA_W / PIPE_REG_ADDR_W : default data word and register index widths
//   mem_wb_payload_t              : one MEM/WB entry at the default widths
//   skid_state_t                  : occupancy of the 2-entry skid buffer; bit 0
//                                   is the main-register valid bit, bit 1 the
//                                   skid-register valid bit
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_REG_ADDR_W = 5;

    typedef struct packed {
        logic                       regwrite;
        logic                       memtoreg;
        logic [PIPE_DATA_W-1:0]     alu_out;
        logic [PIPE_DATA_W-1:0]     read_data;
        logic [PIPE_REG_ADDR_W-1:0] write_reg;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/mem_wb_pipe_if.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_if
// Handshake and payload bundle between the MEM stage, the MEM/WB register and
// the WB stage.
//   in_*      : entry offered by MEM (in_ready returned by the register)
//   out_*     : entry held for WB (out_ready returned by WB)
//   wb_data   : writeback word already selected from the held entry
// Modports:
//   slave  : the pipeline register itself
//   master : the surrounding logic that feeds MEM entries and consumes WB ones
// ---------------------------------------------------------------------------
interface mem_wb_pipe_if
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_regwrite;
    logic                  in_memtoreg;
    logic [DATA_W-1:0]     in_alu_out;
    logic [DATA_W-1:0]     in_read_data;
    logic [REG_ADDR_W-1:0] in_write_reg;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_regwrite;
    logic                  out_memtoreg;
    logic [DATA_W-1:0]     out_alu_out;
    logic [DATA_W-1:0]     out_read_data;
    logic [REG_ADDR_W-1:0] out_write_reg;
    logic [DATA_W-1:0]     wb_data;

    modport slave (
        input  in_valid, in_regwrite, in_memtoreg, in_alu_out, in_read_data,
               in_write_reg, out_ready,
        output in_ready, out_valid, out_regwrite, out_memtoreg, out_alu_out,
               out_read_data, out_write_reg, wb_data
    );

    modport master (
        output in_valid, in_regwrite, in_memtoreg, in_alu_out, in_read_data,
               in_write_reg, out_ready,
        input  in_ready, out_valid, out_regwrite, out_memtoreg, out_alu_out,
               out_read_data, out_write_reg, wb_data
    );

endinterface

// File: rtl/mem_wb_pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry skid buffer over a W-bit vector. A main register M drives
// the output; a skid register S catches the one entry that may arrive in the
// cycle the consumer stalls. in_ready is decoded from registered state only,
// so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   flush                : empties the buffer, drops the entry offered now
//   in_valid/in_ready    : producer handshake, in_data payload
//   out_valid/out_ready  : consumer handshake, out_data payload (from M)
// ---------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  state_next;
    logic [W-1:0] m_data;
    logic [W-1:0] s_data;
    logic         load_m_in;
    logic         load_m_s;
    logic         load_s;
    logic         accept;
    logic         pop;

    assign in_ready  = (state != SKID_FULL);
    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = m_data;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over any handshake: nothing is loaded and the buffer empties.
    // Stale data left in M/S is harmless because the valid bits are cleared.
    always_comb begin
        state_next = state;
        load_m_in  = 1'b0;
        load_m_s   = 1'b0;
        load_s     = 1'b0;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        load_m_in  = 1'b1;
                        state_next = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && pop) begin
                        load_m_in = 1'b1;
                    end else if (accept) begin
                        load_s     = 1'b1;
                        state_next = SKID_FULL;
                    end else if (pop) begin
                        state_next = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        load_m_s   = 1'b1;
                        state_next = SKID_ONE;
                    end
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data <= '0;
            s_data <= '0;
        end else begin
            if (load_m_in) begin
                m_data <= in_data;
            end else if (load_m_s) begin
                m_data <= s_data;
            end
            if (load_s) begin
                s_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
// MEM/WB pipeline register with ready/valid handshake, 2-entry skid buffer,
// synchronous flush, gated register-file write enable and the writeback mux.
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   flush        : discard every held entry and the one offered this cycle
//   bus (slave)  : MEM-side in_* handshake/payload, WB-side out_* handshake/
//                  payload, and wb_data (out_memtoreg ? read data : ALU result)
// Parameters:
//   DATA_W, REG_ADDR_W : data word and register index widths
//   ZERO_REG_GATE      : when 1, an entry targeting register 0 never writes
// Optional build macro MEM_WB_PIPE_PERF_EN adds two saturating counters:
//   stall_cycles : cycles with out_valid & !out_ready
//   flush_count  : cycles with flush asserted
// ---------------------------------------------------------------------------
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W        = PIPE_DATA_W,
    parameter int REG_ADDR_W    = PIPE_REG_ADDR_W,
    parameter bit ZERO_REG_GATE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
`ifdef MEM_WB_PIPE_PERF_EN
    output logic [31:0]   stall_cycles,
    output logic [15:0]   flush_count,
`endif
    mem_wb_pipe_if.slave  bus
);

    // Same field order as pipe_pkg::mem_wb_payload_t, sized by this instance.
    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [DATA_W-1:0]     alu_out;
        logic [DATA_W-1:0]     read_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    payload_t in_payload;
    payload_t m_payload;
    logic     m_valid;
    logic     dest_ok;

    assign in_payload = '{
        regwrite:  bus.in_regwrite,
        memtoreg:  bus.in_memtoreg,
        alu_out:   bus.in_alu_out,
        read_data: bus.in_read_data,
        write_reg: bus.in_write_reg
    };

    pipe_skid_buf #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (m_valid),
        .out_ready (bus.out_ready),
        .out_data  (m_payload)
    );

    // Register 0 is hard-wired in the register file, so writes to it are
    // suppressed here when the gate is enabled; bubbles never write.
    assign dest_ok = ZERO_REG_GATE ? (m_payload.write_reg != '0) : 1'b1;

    assign bus.out_valid     = m_valid;
    assign bus.out_regwrite  = m_payload.regwrite & m_valid & dest_ok;
    assign bus.out_memtoreg  = m_payload.memtoreg;
    assign bus.out_alu_out   = m_payload.alu_out;
    assign bus.out_read_data = m_payload.read_data;
    assign bus.out_write_reg = m_payload.write_reg;
    assign bus.wb_data       = m_payload.memtoreg ? m_payload.read_data
                                                  : m_payload.alu_out;

`ifdef MEM_WB_PIPE_PERF_EN
    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (m_valid && !bus.out_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
